// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: op codes, entry FSM states, default widths.
package calc_pkg;
  localparam int OPW_DEF  = 6;
  localparam int RESW_DEF = 12;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ENT_A,
    ENT_B,
    ISSUE,
    WAIT,
    SHOW
  } state_t;
endpackage

// File: rtl/calc_operand_entry_if.sv
// Operand/result link between the entry front end (master) and the ALU (slave).
interface calc_operand_entry_if import calc_pkg::*; #(
  parameter int OPW  = OPW_DEF,
  parameter int RESW = RESW_DEF
);
  logic [OPW-1:0]  opa;
  logic [OPW-1:0]  opb;
  logic [1:0]      op_sel;
  logic            calc_valid;
  logic            calc_ready;
  logic            res_valid;
  logic [RESW-1:0] res;

  modport master (
    output opa, opb, op_sel, calc_valid,
    input  calc_ready, res_valid, res
  );

  modport slave (
    input  opa, opb, op_sel, calc_valid,
    output calc_ready, res_valid, res
  );
endinterface

// File: rtl/calc_digit_acc.sv
// Hex digit shift accumulator with sticky overflow; load replaces the value, shift appends a nibble.
// One-cycle update, no backpressure; clr restores zero value and clears overflow.
module calc_digit_acc #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           load,
  input  logic [OPW-1:0] ld_val,
  input  logic           shift,
  input  logic [3:0]     nibble,
  output logic [OPW-1:0] acc,
  output logic           ovf
);
  logic [OPW+3:0] shifted;

  assign shifted = {acc, nibble};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= ld_val;
    end else if (shift) begin
      acc <= shifted[OPW-1:0];
      ovf <= ovf | (|shifted[OPW+3:OPW]);
    end
  end
endmodule

// File: rtl/calc_operand_entry.sv
// Calculator key entry: builds A/B/op, issues to the ALU on valid/ready, shows the result; key_eq->calc_valid 1 cycle,
// res_valid->display 1 cycle; request held frozen until calc_ready. CALC_DIV0_CHECK_EN enables local divide-by-zero trap.
module calc_operand_entry import calc_pkg::*; #(
  parameter int OPW  = OPW_DEF,
  parameter int RESW = RESW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  input  logic                 key_op,
  input  logic [1:0]           op_in,
  input  logic                 key_eq,
  input  logic                 key_clr,
  calc_operand_entry_if.master alu,
  output logic [3:0]           H0,
  output logic [3:0]           H1,
  output logic [3:0]           H2,
  output logic [3:0]           H3,
  output logic                 ovf,
  output logic                 err
);
  state_t          state;
  logic [OPW-1:0]  acc;
  logic [OPW-1:0]  opa_q;
  logic [1:0]      op_sel_q;
  logic            calc_valid_q;
  logic [RESW-1:0] result_q;
  logic            err_q;

  // Only the highest-priority strobe of a cycle acts.
  logic ev_op, ev_eq, ev_dig;
  assign ev_op  = key_op & ~key_clr;
  assign ev_eq  = key_eq & ~key_op & ~key_clr;
  assign ev_dig = key_valid & ~key_eq & ~key_op & ~key_clr;

  logic div0;
`ifdef CALC_DIV0_CHECK_EN
  assign div0 = (op_sel_q == OP_DIV) && (acc == '0);
`else
  assign div0 = 1'b0;
`endif

  logic           acc_load, acc_shift;
  logic [OPW-1:0] acc_ld_val;

  always_comb begin
    acc_load   = 1'b0;
    acc_shift  = 1'b0;
    acc_ld_val = '0;
    unique case (state)
      ENT_A: begin
        if (ev_op)       acc_load  = 1'b1;
        else if (ev_dig) acc_shift = 1'b1;
      end
      ENT_B: begin
        if (ev_dig) acc_shift = 1'b1;
      end
      SHOW: begin
        if (ev_op) begin
          acc_load = 1'b1;
        end else if (ev_dig) begin
          acc_load   = 1'b1;
          acc_ld_val = OPW'(key_code);
        end
      end
      default: ;
    endcase
  end

  calc_digit_acc #(.OPW(OPW)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (key_clr),
    .load   (acc_load),
    .ld_val (acc_ld_val),
    .shift  (acc_shift),
    .nibble (key_code),
    .acc    (acc),
    .ovf    (ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || key_clr) begin
      state        <= ENT_A;
      opa_q        <= '0;
      op_sel_q     <= 2'b00;
      calc_valid_q <= 1'b0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      if (ev_op || ev_dig) err_q <= 1'b0;
      unique case (state)
        ENT_A: begin
          if (ev_op) begin
            opa_q    <= acc;
            op_sel_q <= op_in;
            state    <= ENT_B;
          end
        end
        ENT_B: begin
          if (ev_op) begin
            op_sel_q <= op_in;
          end else if (ev_eq) begin
            if (div0) begin
              err_q    <= 1'b1;
              result_q <= '0;
              state    <= SHOW;
            end else begin
              calc_valid_q <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (alu.calc_ready) begin
            calc_valid_q <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (alu.res_valid) begin
            result_q <= alu.res;
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (ev_op) begin
            opa_q    <= result_q[OPW-1:0];
            op_sel_q <= op_in;
            state    <= ENT_B;
          end else if (ev_dig) begin
            state <= ENT_A;
          end
        end
        default: state <= ENT_A;
      endcase
    end
  end

  // The accumulator is the operand being typed: A in ENT_A, B everywhere else.
  assign alu.opa        = (state == ENT_A) ? acc : opa_q;
  assign alu.opb        = (state == ENT_A) ? '0 : acc;
  assign alu.op_sel     = op_sel_q;
  assign alu.calc_valid = calc_valid_q;
  assign err            = err_q;

  logic [15:0] disp;
  logic [7:0]  opd8;

  always_comb begin
    opd8 = 8'(acc);
    if (state == SHOW)
      disp = 16'(result_q);
    else
      disp = {((state == ENT_B) ? {2'b00, op_sel_q} : 4'h0), 4'h0, opd8};
  end

  assign H0 = disp[3:0];
  assign H1 = disp[7:4];
  assign H2 = disp[11:8];
  assign H3 = disp[15:12];
endmodule

// File: tb/tb_calc_operand_entry.sv
// Bench for calc_operand_entry: directed vector table, hand sequences, then random keys against a reference model.
module tb_calc_operand_entry;
  import calc_pkg::*;

`ifdef CALC_DIV0_CHECK_EN
  localparam bit DIV0_EN = 1'b1;
`else
  localparam bit DIV0_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid, key_op, key_eq, key_clr;
  logic [3:0] key_code;
  logic [1:0] op_in;
  logic [3:0] H0, H1, H2, H3;
  logic       ovf, err;

  int checks = 0;
  int failures = 0;

  calc_operand_entry_if #(.OPW(6), .RESW(12)) alu_if ();

  calc_operand_entry #(.OPW(6), .RESW(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_op    (key_op),
    .op_in     (op_in),
    .key_eq    (key_eq),
    .key_clr   (key_clr),
    .alu       (alu_if),
    .H0        (H0),
    .H1        (H1),
    .H2        (H2),
    .H3        (H3),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        kv;
    logic [3:0]  kc;
    logic        ko;
    logic [1:0]  oi;
    logic        ke;
    logic        kclr;
    logic        rdy;
    logic        rv;
    logic [11:0] res;
    logic [5:0]  e_opa;
    logic [5:0]  e_opb;
    logic [1:0]  e_op;
    logic        e_cv;
    logic        e_ovf;
    logic        chk_h;
    logic [15:0] e_h;
  } vec_t;

  vec_t vt[$];

  task automatic add(input string nm, input logic kv, input logic [3:0] kc, input logic ko,
                     input logic [1:0] oi, input logic ke, input logic kclr, input logic rdy,
                     input logic rv, input logic [11:0] res, input logic [5:0] e_opa,
                     input logic [5:0] e_opb, input logic [1:0] e_op, input logic e_cv,
                     input logic e_ovf, input logic chk_h, input logic [15:0] e_h);
    vt.push_back('{nm, kv, kc, ko, oi, ke, kclr, rdy, rv, res, e_opa, e_opb, e_op, e_cv, e_ovf, chk_h, e_h});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    key_valid = 1'b0; key_code = 4'h0; key_op = 1'b0; op_in = 2'b00;
    key_eq = 1'b0; key_clr = 1'b0;
    alu_if.calc_ready = 1'b0; alu_if.res_valid = 1'b0; alu_if.res = 12'h000;
  endtask

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] core_snap();
    return 40'({alu_if.opa, alu_if.opb, alu_if.op_sel, alu_if.calc_valid, ovf, err});
  endfunction

  function automatic logic [39:0] h_snap();
    return 40'({H3, H2, H1, H0});
  endfunction

  function automatic logic [39:0] full_snap();
    return 40'({alu_if.opa, alu_if.opb, alu_if.op_sel, alu_if.calc_valid, H3, H2, H1, H0, ovf, err});
  endfunction

  task automatic key_digit(input logic [3:0] d);
    key_valid = 1'b1; key_code = d; tick(); clear_in();
  endtask

  task automatic key_oper(input logic [1:0] o);
    key_op = 1'b1; op_in = o; tick(); clear_in();
  endtask

  // Reference model: operand values, pending op and phase of the calculation.
  localparam int P_A = 0, P_B = 1, P_ISS = 2, P_WAIT = 3, P_SHOW = 4;
  int m_ph, m_a, m_b, m_op, m_res;
  bit m_ovf, m_err;

  function automatic int push_digit(input int v, input int d);
    int t;
    t = v * 16 + d;
    if (t / 64 != 0) m_ovf = 1'b1;
    return t % 64;
  endfunction

  task automatic model_step(input bit rst, input bit kv, input int kc, input bit ko, input int oi,
                            input bit ke, input bit kclr, input bit rdy, input bit rv, input int res);
    bit dig;
    if (!rst || kclr) begin
      m_ph = P_A; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_ovf = 0; m_err = 0;
      return;
    end
    dig = kv && !ke && !ko;
    if (ko || dig) m_err = 0;
    case (m_ph)
      P_A: begin
        if (ko) begin m_op = oi; m_b = 0; m_ph = P_B; end
        else if (dig) m_a = push_digit(m_a, kc);
      end
      P_B: begin
        if (ko) m_op = oi;
        else if (ke) begin
          if (DIV0_EN && m_op == 3 && m_b == 0) begin m_err = 1; m_res = 0; m_ph = P_SHOW; end
          else m_ph = P_ISS;
        end else if (dig) m_b = push_digit(m_b, kc);
      end
      P_ISS:  if (rdy) m_ph = P_WAIT;
      P_WAIT: if (rv) begin m_res = res; m_ph = P_SHOW; end
      default: begin
        if (ko) begin m_a = m_res % 64; m_b = 0; m_op = oi; m_ph = P_B; end
        else if (dig) begin m_a = kc; m_b = 0; m_ph = P_A; end
      end
    endcase
  endtask

  function automatic logic [39:0] model_snap();
    int h;
    if (m_ph == P_SHOW) h = m_res;
    else h = ((m_ph == P_B) ? m_op * 4096 : 0) + ((m_ph == P_A) ? m_a : m_b);
    return 40'({6'(m_a), 6'(m_b), 2'(m_op), (m_ph == P_ISS), 16'(h), m_ovf, m_err});
  endfunction

  initial begin
    rst_n = 1'b0;
    clear_in();
    tick();
    tick();
    chk("reset", full_snap(), 40'h0);
    rst_n = 1'b1;

    //   name       kv kc   ko oi ke clr rdy rv res      opa    opb    op cv ovf chkh H
    add("a_d3",     1, 3,   0, 0, 0, 0,  0,  0, 12'h000, 6'h03, 6'h00, 0, 0, 0,  1, 16'h0003);
    add("a_dA",     1, 'hA, 0, 0, 0, 0,  0,  0, 12'h000, 6'h3A, 6'h00, 0, 0, 0,  1, 16'h003A);
    add("op_add",   0, 0,   1, 0, 0, 0,  0,  0, 12'h000, 6'h3A, 6'h00, 0, 0, 0,  1, 16'h0000);
    add("b_d1",     1, 1,   0, 0, 0, 0,  0,  0, 12'h000, 6'h3A, 6'h01, 0, 0, 0,  1, 16'h0001);
    add("b_d2",     1, 2,   0, 0, 0, 0,  0,  0, 12'h000, 6'h3A, 6'h12, 0, 0, 0,  1, 16'h0012);
    add("eq",       0, 0,   0, 0, 1, 0,  0,  0, 12'h000, 6'h3A, 6'h12, 0, 1, 0,  0, 16'h0000);
    add("xfer",     0, 0,   0, 0, 0, 0,  1,  0, 12'h000, 6'h3A, 6'h12, 0, 0, 0,  0, 16'h0000);
    add("res",      0, 0,   0, 0, 0, 0,  0,  1, 12'h04C, 6'h3A, 6'h12, 0, 0, 0,  1, 16'h004C);
    add("show_d7",  1, 7,   0, 0, 0, 0,  0,  0, 12'h000, 6'h07, 6'h00, 0, 0, 0,  1, 16'h0007);
    add("clr1",     0, 0,   0, 0, 0, 1,  0,  0, 12'h000, 6'h00, 6'h00, 0, 0, 0,  1, 16'h0000);
    add("ovf_d1",   1, 1,   0, 0, 0, 0,  0,  0, 12'h000, 6'h01, 6'h00, 0, 0, 0,  1, 16'h0001);
    add("ovf_d2",   1, 2,   0, 0, 0, 0,  0,  0, 12'h000, 6'h12, 6'h00, 0, 0, 0,  1, 16'h0012);
    add("ovf_d3",   1, 3,   0, 0, 0, 0,  0,  0, 12'h000, 6'h23, 6'h00, 0, 0, 1,  1, 16'h0023);
    add("clr_ovf",  0, 0,   0, 0, 0, 1,  0,  0, 12'h000, 6'h00, 6'h00, 0, 0, 0,  1, 16'h0000);
    add("prio_op",  1, 5,   1, 1, 1, 0,  0,  0, 12'h000, 6'h00, 6'h00, 1, 0, 0,  1, 16'h1000);
    add("prio_clr", 0, 0,   1, 2, 0, 1,  0,  0, 12'h000, 6'h00, 6'h00, 0, 0, 0,  1, 16'h0000);
    add("ch_dF",    1, 'hF, 0, 0, 0, 0,  0,  0, 12'h000, 6'h0F, 6'h00, 0, 0, 0,  1, 16'h000F);
    add("ch_mul",   0, 0,   1, 2, 0, 0,  0,  0, 12'h000, 6'h0F, 6'h00, 2, 0, 0,  1, 16'h2000);
    add("ch_d1",    1, 1,   0, 0, 0, 0,  0,  0, 12'h000, 6'h0F, 6'h01, 2, 0, 0,  1, 16'h2001);
    add("ch_eq",    0, 0,   0, 0, 1, 0,  0,  0, 12'h000, 6'h0F, 6'h01, 2, 1, 0,  0, 16'h0000);
    add("ch_xfer",  0, 0,   0, 0, 0, 0,  1,  0, 12'h000, 6'h0F, 6'h01, 2, 0, 0,  0, 16'h0000);
    add("ch_res",   0, 0,   0, 0, 0, 0,  0,  1, 12'h0FF, 6'h0F, 6'h01, 2, 0, 0,  1, 16'h00FF);
    add("chain",    0, 0,   1, 0, 0, 0,  0,  0, 12'h000, 6'h3F, 6'h00, 0, 0, 0,  1, 16'h0000);
    add("clr2",     0, 0,   0, 0, 0, 1,  0,  0, 12'h000, 6'h00, 6'h00, 0, 0, 0,  1, 16'h0000);

    foreach (vt[i]) begin
      key_valid = vt[i].kv; key_code = vt[i].kc; key_op = vt[i].ko; op_in = vt[i].oi;
      key_eq = vt[i].ke; key_clr = vt[i].kclr;
      alu_if.calc_ready = vt[i].rdy; alu_if.res_valid = vt[i].rv; alu_if.res = vt[i].res;
      tick();
      chk(vt[i].name, core_snap(),
          40'({vt[i].e_opa, vt[i].e_opb, vt[i].e_op, vt[i].e_cv, vt[i].e_ovf, 1'b0}));
      if (vt[i].chk_h) chk({vt[i].name, "_h"}, h_snap(), 40'(vt[i].e_h));
      clear_in();
    end

    // calc_ready low for 5 cycles: request frozen, stray digits ignored, transfer on the 6th.
    key_digit(4'h5);
    key_oper(OP_SUB);
    key_digit(4'h9);
    key_eq = 1'b1; tick(); clear_in();
    chk("hold_c0", core_snap(), 40'({6'h05, 6'h09, OP_SUB, 1'b1, 1'b0, 1'b0}));
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1; key_code = 4'hE; alu_if.calc_ready = 1'b0;
      tick(); clear_in();
      chk("hold", core_snap(), 40'({6'h05, 6'h09, OP_SUB, 1'b1, 1'b0, 1'b0}));
    end
    alu_if.calc_ready = 1'b1; tick(); clear_in();
    chk("hold_xfer", core_snap(), 40'({6'h05, 6'h09, OP_SUB, 1'b0, 1'b0, 1'b0}));
    alu_if.res_valid = 1'b1; alu_if.res = 12'h123; tick(); clear_in();
    chk("hold_res_h", h_snap(), 40'h0123);

    // Clear while waiting for the result; the late result must not land.
    key_clr = 1'b1; tick(); clear_in();
    key_digit(4'h2); key_oper(OP_ADD); key_digit(4'h3);
    key_eq = 1'b1; tick(); clear_in();
    alu_if.calc_ready = 1'b1; tick(); clear_in();
    key_clr = 1'b1; tick(); clear_in();
    chk("wclr", full_snap(), 40'h0);
    alu_if.res_valid = 1'b1; alu_if.res = 12'hABC; tick(); clear_in();
    chk("wclr_late", full_snap(), 40'h0);

    // Clear coinciding with calc_ready in ISSUE: no transfer, request dropped.
    key_digit(4'h2); key_oper(OP_ADD); key_digit(4'h3);
    key_eq = 1'b1; tick(); clear_in();
    key_clr = 1'b1; alu_if.calc_ready = 1'b1; tick(); clear_in();
    chk("iclr", full_snap(), 40'h0);
    alu_if.res_valid = 1'b1; alu_if.res = 12'hFFF; tick(); clear_in();
    chk("iclr_late", full_snap(), 40'h0);

    // Divide by zero.
    key_digit(4'h7); key_oper(OP_DIV);
    key_eq = 1'b1; tick(); clear_in();
    chk("div0", 40'({alu_if.calc_valid, err}), 40'({!DIV0_EN, DIV0_EN}));
    alu_if.calc_ready = 1'b1; tick();
    chk("div0_cv", 40'(alu_if.calc_valid), 40'h0);
    tick(); clear_in();
    chk("div0_cv2", 40'(alu_if.calc_valid), 40'h0);
    key_digit(4'h1);
    chk("div0_errclr", 40'(err), 40'h0);
    key_clr = 1'b1; tick(); clear_in();

    // Random keys and ALU responses against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit b_rst, b_kv, b_ko, b_ke, b_kclr, b_rdy, b_rv;
      int v_kc, v_oi, v_res;
      r      = $urandom_range(0, 99);
      b_kv   = (r < 35) || ($urandom_range(0, 9) == 0);
      b_ko   = (r >= 35 && r < 45) || ($urandom_range(0, 19) == 0);
      b_ke   = (r >= 45 && r < 57);
      b_kclr = ($urandom_range(0, 59) == 0);
      b_rst  = (n != 0) && ($urandom_range(0, 149) != 0);
      b_rdy  = ($urandom_range(0, 2) != 0);
      b_rv   = ($urandom_range(0, 2) == 0);
      v_kc   = $urandom_range(0, 15);
      v_oi   = $urandom_range(0, 3);
      v_res  = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) == 0) v_kc = 0;
      rst_n = b_rst; key_valid = b_kv; key_code = 4'(v_kc); key_op = b_ko; op_in = 2'(v_oi);
      key_eq = b_ke; key_clr = b_kclr;
      alu_if.calc_ready = b_rdy; alu_if.res_valid = b_rv; alu_if.res = 12'(v_res);
      model_step(b_rst, b_kv, v_kc, b_ko, v_oi, b_ke, b_kclr, b_rdy, b_rv, v_res);
      tick();
      chk("rand", full_snap(), model_snap());
    end
    rst_n = 1'b1;
    clear_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
